// File: rtl/adder_serial_nb_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// Carries oOvf only when ADDER_SERIAL_OVF_EN is defined.
interface adder_serial_nb_if #(
    parameter int WIDTH = 16
);
    logic             iStart;
    logic             iSub;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iC_in;
    logic [WIDTH-1:0] oS;
    logic             oC_out;
    logic             oBusy;
    logic             oDone;
`ifdef ADDER_SERIAL_OVF_EN
    logic             oOvf;
`endif

    modport master (
        output iStart, iSub, iA, iB, iC_in,
`ifdef ADDER_SERIAL_OVF_EN
        input  oOvf,
`endif
        input  oS, oC_out, oBusy, oDone
    );

    modport slave (
        input  iStart, iSub, iA, iB, iC_in,
`ifdef ADDER_SERIAL_OVF_EN
        output oOvf,
`endif
        output oS, oC_out, oBusy, oDone
    );
endinterface

// File: rtl/adder_serial_nb.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output oOvf enabled by defining ADDER_SERIAL_OVF_EN.
module adder_serial_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic              iClk,
    input logic              iRst_n,
    adder_serial_nb_if.slave bus
);
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int N          = WIDTH / CHUNK_SAFE;
    localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK_SAFE != 0)) begin : gBadParam
            $error("adder_serial_nb: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] sumReg;
    logic [WIDTH-1:0] sumNext;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             lastChunk;
    logic [CHUNK:0]   chunkFull;

    assign chunkFull = {1'b0, aReg[CHUNK-1:0]} + {1'b0, bReg[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry};
    // New chunk enters at the top; after N shifts the result is aligned.
    assign sumNext   = WIDTH'({chunkFull[CHUNK-1:0], sumReg} >> CHUNK);
    assign lastChunk = (cnt == CNT_W'(N - 1));

`ifdef ADDER_SERIAL_OVF_EN
    logic carryIntoTop;
    // Carry into the MSB recovered from sum bit and operand bits of the top position.
    assign carryIntoTop = chunkFull[CHUNK-1] ^ aReg[CHUNK-1] ^ bReg[CHUNK-1];
`endif

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        bus.oBusy = 1'b0;
        bus.oDone = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) stateNext = RUN;
            end
            RUN: begin
                bus.oBusy = 1'b1;
                if (lastChunk) stateNext = DONE;
            end
            DONE: begin
                bus.oDone = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            aReg       <= '0;
            bReg       <= '0;
            sumReg     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            bus.oS     <= '0;
            bus.oC_out <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
            bus.oOvf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        aReg  <= bus.iA;
                        bReg  <= bus.iSub ? ~bus.iB : bus.iB;
                        carry <= bus.iSub ? ~bus.iC_in : bus.iC_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    aReg   <= aReg >> CHUNK;
                    bReg   <= bReg >> CHUNK;
                    sumReg <= sumNext;
                    carry  <= chunkFull[CHUNK];
                    cnt    <= cnt + 1'b1;
                    if (lastChunk) begin
                        bus.oS     <= sumNext;
                        bus.oC_out <= chunkFull[CHUNK];
`ifdef ADDER_SERIAL_OVF_EN
                        bus.oOvf   <= carryIntoTop ^ chunkFull[CHUNK];
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_serial_nb.sv
// Randomised and directed bench for adder_serial_nb (CHUNK=4 and CHUNK=16 instances).
// Expected results come from plain integer arithmetic on the operands.
module tb_adder_serial_nb;
    logic clk = 1'b0;
    logic rstN;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    adder_serial_nb_if #(.WIDTH(16)) bus4();
    adder_serial_nb_if #(.WIDTH(16)) bus16();

    adder_serial_nb #(.WIDTH(16), .CHUNK(4))  dut4  (.iClk(clk), .iRst_n(rstN), .bus(bus4));
    adder_serial_nb #(.WIDTH(16), .CHUNK(16)) dut16 (.iClk(clk), .iRst_n(rstN), .bus(bus16));

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {signed overflow, carry/no-borrow, 16-bit result}.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic sub, input logic cin);
        longint ua = a;
        longint ub = b;
        longint uc = cin;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ur, sr;
        logic   cout, ovf;
        if (!sub) begin
            ur   = ua + ub + uc;
            cout = (ur >= 65536);
            sr   = sa + sb + uc;
        end else begin
            ur   = ua - ub - uc;
            cout = (ua >= ub + uc);
            sr   = sa - sb - uc;
        end
        ovf = (sr > 32767) || (sr < -32768);
        return {ovf, cout, ur[15:0]};
    endfunction

    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input string tag);
        logic [17:0] exp;
        logic [15:0] prevS;
        int          busyCnt = 0;
        int          doneAt  = -1;
        bit          holdBad = 0;
        exp = refModel(a, b, sub, cin);
        @(negedge clk);
        bus4.iStart = 1'b1; bus4.iA = a; bus4.iB = b; bus4.iSub = sub; bus4.iC_in = cin;
        prevS = bus4.oS;
        @(negedge clk);
        bus4.iStart = 1'b0;
        bus4.iA = 16'($urandom); bus4.iB = 16'($urandom);
        bus4.iSub = 1'($urandom); bus4.iC_in = 1'($urandom);
        for (int i = 0; i < 20 && doneAt < 0; i++) begin
            if (bus4.oDone) begin
                doneAt = i;
            end else begin
                if (bus4.oBusy) busyCnt++;
                if (bus4.oS !== prevS) holdBad = 1;
                @(negedge clk);
            end
        end
        checkVal({tag, " latency"}, doneAt, 4);
        checkVal({tag, " busy"}, busyCnt, 4);
        checkVal({tag, " hold"}, {31'd0, holdBad}, 0);
        checkVal({tag, " s"}, bus4.oS, exp[15:0]);
        checkVal({tag, " cout"}, bus4.oC_out, exp[16]);
`ifdef ADDER_SERIAL_OVF_EN
        checkVal({tag, " ovf"}, bus4.oOvf, exp[17]);
`endif
        @(negedge clk);
        checkVal({tag, " pulse"}, {bus4.oDone, bus4.oBusy}, 2'b00);
        checkVal({tag, " s held"}, bus4.oS, exp[15:0]);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin, input string tag);
        logic [17:0] exp;
        exp = refModel(a, b, sub, cin);
        @(negedge clk);
        bus16.iStart = 1'b1; bus16.iA = a; bus16.iB = b; bus16.iSub = sub; bus16.iC_in = cin;
        @(negedge clk);
        bus16.iStart = 1'b0; bus16.iA = 16'($urandom); bus16.iB = 16'($urandom);
        checkVal({tag, " run"}, {bus16.oBusy, bus16.oDone}, 2'b10);
        @(negedge clk);
        checkVal({tag, " done"}, {bus16.oBusy, bus16.oDone}, 2'b01);
        checkVal({tag, " s"}, bus16.oS, exp[15:0]);
        checkVal({tag, " cout"}, bus16.oC_out, exp[16]);
`ifdef ADDER_SERIAL_OVF_EN
        checkVal({tag, " ovf"}, bus16.oOvf, exp[17]);
`endif
        @(negedge clk);
        checkVal({tag, " pulse"}, bus16.oDone, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dones;
        int firstAt;
        int secondAt;
        logic [15:0] sAtDone;

        rstN = 1'b0;
        bus4.iStart = 0; bus4.iSub = 0; bus4.iA = 0; bus4.iB = 0; bus4.iC_in = 0;
        bus16.iStart = 0; bus16.iSub = 0; bus16.iA = 0; bus16.iB = 0; bus16.iC_in = 0;
        repeat (3) @(negedge clk);
        checkVal("reset dut4", {bus4.oS, bus4.oC_out, bus4.oBusy, bus4.oDone}, '0);
        checkVal("reset dut16", {bus16.oS, bus16.oC_out, bus16.oBusy, bus16.oDone}, '0);
`ifdef ADDER_SERIAL_OVF_EN
        checkVal("reset ovf", bus4.oOvf, 1'b0);
`endif
        rstN = 1'b1;

        run4(16'h1234, 16'h4321, 1'b0, 1'b0, "add basic");
        run4(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add wrap");
        run4(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add ovf");
        run4(16'h0005, 16'h0007, 1'b1, 1'b0, "sub borrow");
        run4(16'h0009, 16'h0003, 1'b1, 1'b1, "sub bin");
        run4(16'h8000, 16'h0001, 1'b1, 1'b0, "sub ovf");

        // Start request during RUN must be ignored.
        @(negedge clk);
        bus4.iStart = 1'b1; bus4.iA = 16'h0010; bus4.iB = 16'h0020; bus4.iSub = 0; bus4.iC_in = 0;
        @(negedge clk);
        bus4.iA = 16'hAAAA; bus4.iB = 16'h1111;
        @(negedge clk);
        bus4.iStart = 1'b0;
        dones = 0; sAtDone = '0;
        for (int i = 0; i < 14; i++) begin
            if (bus4.oDone) begin dones++; sAtDone = bus4.oS; end
            @(negedge clk);
        end
        checkVal("ignore start dones", dones, 1);
        checkVal("ignore start s", sAtDone, 16'h0030);

        // Held start: back-to-back operations every N+2 cycles.
        bus4.iStart = 1'b1; bus4.iA = 16'h0102; bus4.iB = 16'h0304; bus4.iSub = 0; bus4.iC_in = 0;
        dones = 0; firstAt = -1; secondAt = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus4.oDone) begin
                dones++;
                if (firstAt < 0) firstAt = i; else secondAt = i;
            end
        end
        bus4.iStart = 1'b0;
        checkVal("held start dones", dones, 2);
        checkVal("held start first", firstAt, 5);
        checkVal("held start second", secondAt, 11);
        checkVal("held start s", bus4.oS, 16'h0406);

        // Reset in the 2nd RUN cycle aborts the operation.
        run4(16'h9999, 16'h9999, 1'b0, 1'b0, "pre reset");
        @(negedge clk);
        bus4.iStart = 1'b1; bus4.iA = 16'h0100; bus4.iB = 16'h0200;
        @(negedge clk);
        bus4.iStart = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkVal("abort outputs", {bus4.oS, bus4.oC_out, bus4.oBusy, bus4.oDone}, '0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.oDone) dones++;
            @(negedge clk);
        end
        checkVal("abort no done", dones, 0);
        run4(16'd3, 16'd4, 1'b0, 1'b0, "after reset");

        run16(16'hBEEF, 16'h1111, 1'b0, 1'b1, "c16 plan");
        run16(16'h7FFF, 16'h7FFF, 1'b0, 1'b1, "c16 ovf");

        for (int k = 0; k < 24; k++) begin
            run4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand4");
        end
        for (int k = 0; k < 8; k++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand16");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
